// File: rtl/word_tx_serializer.sv
`default_nettype none
// ============================================================================
//  Module      : word_tx_serializer
//  Description : Splits an NBITS debug word into DBIT-wide bytes and hands
//                them one at a time to a byte UART transmitter, waiting for
//                byte_done between bytes. Flags dropped requests as overrun.
//  Options     : define WORD_TX_MSB_FIRST_EN to send the most-significant
//                byte first (left shifts); default is least-significant first.
//  Revision    : 1.0 - initial release
// ============================================================================
module word_tx_serializer #(
  parameter int NBITS = 32,  // must be an integer multiple of DBIT
  parameter int DBIT  = 8
) (
  input  logic             clk,
  input  logic             rst,         // asynchronous, active-low
  input  logic             word_start,
  input  logic [NBITS-1:0] word_data,
  input  logic             byte_done,
  output logic             byte_start,
  output logic [DBIT-1:0]  byte_data,
  output logic             word_done,
  output logic             busy,
  output logic             overrun
);

  localparam int NBYTES = NBITS / DBIT;
  localparam int CNT_W  = (NBYTES > 1) ? $clog2(NBYTES) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NBYTES - 1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_START = 2'd1;
  localparam logic [1:0] S_WAIT  = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  logic [1:0]       state_q,   state_d;
  logic [NBITS-1:0] shreg_q,   shreg_d;
  logic [CNT_W-1:0] cnt_q,     cnt_d;
  logic             overrun_q, overrun_d;

  // Next-state, shift-register, byte-counter and overrun logic
  always_comb begin
    state_d   = state_q;
    shreg_d   = shreg_q;
    cnt_d     = cnt_q;
    overrun_d = overrun_q;
    case (state_q)
      S_IDLE: begin
        // A new word wins over any stray byte_done in the same cycle
        if (word_start) begin
          shreg_d   = word_data;
          cnt_d     = '0;
          overrun_d = 1'b0;
          state_d   = S_START;
        end
      end
      S_START: begin
        state_d = S_WAIT;
      end
      S_WAIT: begin
        if (byte_done) begin
          if (cnt_q == LAST_CNT) begin
            state_d = S_DONE;
          end else begin
            // Shift now so the next byte is on byte_data together with byte_start
`ifdef WORD_TX_MSB_FIRST_EN
            shreg_d = shreg_q << DBIT;
`else
            shreg_d = shreg_q >> DBIT;
`endif
            cnt_d   = cnt_q + CNT_W'(1);
            state_d = S_START;
          end
        end
      end
      default: begin  // S_DONE
        state_d = S_IDLE;
      end
    endcase
    // A request arriving while a word is in flight is dropped but remembered
    if (state_q != S_IDLE && word_start) begin
      overrun_d = 1'b1;
    end
  end

  // State registers with asynchronous active-low reset
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= S_IDLE;
      shreg_q   <= '0;
      cnt_q     <= '0;
      overrun_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      shreg_q   <= shreg_d;
      cnt_q     <= cnt_d;
      overrun_q <= overrun_d;
    end
  end

  // Outputs decode directly from registered state, so reset clears them at once
  assign byte_start = (state_q == S_START);
  assign word_done  = (state_q == S_DONE);
  assign busy       = (state_q != S_IDLE);
  assign overrun    = overrun_q;
`ifdef WORD_TX_MSB_FIRST_EN
  assign byte_data  = shreg_q[NBITS-1 -: DBIT];
`else
  assign byte_data  = shreg_q[DBIT-1:0];
`endif

endmodule
`default_nettype wire

// File: tb/tb_word_tx_serializer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_word_tx_serializer
//  Description : Self-checking bench for word_tx_serializer with a byte-level
//                reference model and a handshake driver acting as the UART.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_word_tx_serializer;

  localparam int NBITS  = 32;
  localparam int DBIT   = 8;
  localparam int NBYTES = NBITS / DBIT;

  logic             clk;
  logic             rst;
  logic             word_start;
  logic [NBITS-1:0] word_data;
  logic             byte_done;
  logic             byte_start;
  logic [DBIT-1:0]  byte_data;
  logic             word_done;
  logic             busy;
  logic             overrun;

  int vectors;
  int miscompares;

  // Observation state filled by the monitor
  logic [DBIT-1:0] obs_q[$];
  int              wd_cnt;
  int              unstable;
  logic [DBIT-1:0] held;

  word_tx_serializer #(.NBITS(NBITS), .DBIT(DBIT)) dut (
    .clk        (clk),
    .rst        (rst),
    .word_start (word_start),
    .word_data  (word_data),
    .byte_done  (byte_done),
    .byte_start (byte_start),
    .byte_data  (byte_data),
    .word_done  (word_done),
    .busy       (busy),
    .overrun    (overrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Monitor: records bytes offered at each byte_start and counts word_done
  always @(negedge clk) begin
    if (rst) begin
      if (byte_start) begin
        obs_q.push_back(byte_data);
        held = byte_data;
      end else if (busy && byte_data !== held) begin
        unstable++;
      end
      if (word_done) wd_cnt++;
    end
  end

  // Reference: i-th byte on the line for word w
  function automatic logic [DBIT-1:0] exp_byte(input logic [NBITS-1:0] w, input int i);
    logic [NBITS-1:0] s;
`ifdef WORD_TX_MSB_FIRST_EN
    s = w >> (DBIT * (NBYTES - 1 - i));
`else
    s = w >> (DBIT * i);
`endif
    return s[DBIT-1:0];
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_obs();
    obs_q.delete();
    wd_cnt   = 0;
    unstable = 0;
  endtask

  // Plays both the debug controller and the byte UART for one word.
  //   gap         : cycles from byte_start to byte_done
  //   spurious    : also drive byte_done in the accept, START and DONE cycles
  //   inject_at   : byte index during whose WAIT a second word_start is issued (-1 none)
  //   abort_after : return right after this many byte_done pulses (0 = full word)
  task automatic send_word(input logic [NBITS-1:0] w, input int gap, input bit spurious,
                           input int inject_at, input int abort_after,
                           output bit start_lat_ok, output bit done_lat_ok,
                           output bit ovr_cleared, output bit timed_out);
    int n;
    start_lat_ok = 1'b0;
    done_lat_ok  = 1'b0;
    timed_out    = 1'b0;
    word_data  = w;
    word_start = 1'b1;
    byte_done  = spurious;
    tick();
    word_start = 1'b0;
    byte_done  = 1'b0;
    word_data  = NBITS'($urandom);
    start_lat_ok = (byte_start === 1'b1);
    ovr_cleared  = (overrun === 1'b0);
    for (int i = 0; i < NBYTES; i++) begin
      n = 0;
      while (byte_start !== 1'b1 && n < 20) begin
        tick();
        n++;
      end
      if (n >= 20) begin
        timed_out = 1'b1;
        return;
      end
      if (spurious) byte_done = 1'b1;
      for (int g = 1; g <= gap; g++) begin
        tick();
        byte_done  = 1'b0;
        word_start = 1'b0;
        if (inject_at == i && g == 1) begin
          word_start = 1'b1;
          word_data  = 32'h1122_3344;
        end
      end
      byte_done = 1'b1;
      tick();
      byte_done  = 1'b0;
      word_start = 1'b0;
      if (i + 1 == abort_after) return;
      if (i == NBYTES - 1) begin
        done_lat_ok = (word_done === 1'b1) && (busy === 1'b1);
        if (spurious) byte_done = 1'b1;
        tick();
        byte_done = 1'b0;
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b0;
    #2;
    vectors++; if (byte_start !== 1'b0) begin miscompares++; $display("FAIL reset_byte_start got=%b exp=0", byte_start); end
    vectors++; if (byte_data !== '0) begin miscompares++; $display("FAIL reset_byte_data got=%h exp=00", byte_data); end
    vectors++; if (word_done !== 1'b0) begin miscompares++; $display("FAIL reset_word_done got=%b exp=0", word_done); end
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL reset_busy got=%b exp=0", busy); end
    vectors++; if (overrun !== 1'b0) begin miscompares++; $display("FAIL reset_overrun got=%b exp=0", overrun); end
    repeat (2) tick();
    rst = 1'b1;
    tick();
  endtask

  task automatic test_basic();
    bit sl, dl, oc, to;
    logic [NBITS-1:0] w;
    w = 32'hA1B2_C3D4;
    clear_obs();
    send_word(w, 5, 1'b0, -1, 0, sl, dl, oc, to);
    vectors++; if (to) begin miscompares++; $display("FAIL basic_timeout got=1 exp=0"); end
    vectors++; if (!sl) begin miscompares++; $display("FAIL basic_start_latency got=late exp=next_cycle"); end
    vectors++; if (!dl) begin miscompares++; $display("FAIL basic_done_latency got=late exp=next_cycle"); end
    vectors++; if (obs_q.size() != NBYTES) begin miscompares++; $display("FAIL basic_byte_count got=%0d exp=%0d", obs_q.size(), NBYTES); end
    for (int i = 0; i < NBYTES && i < obs_q.size(); i++) begin
      vectors++;
      if (obs_q[i] !== exp_byte(w, i)) begin
        miscompares++; $display("FAIL basic_byte%0d got=%h exp=%h", i, obs_q[i], exp_byte(w, i));
      end
    end
    vectors++; if (wd_cnt != 1) begin miscompares++; $display("FAIL basic_word_done_count got=%0d exp=1", wd_cnt); end
    vectors++; if (unstable != 0) begin miscompares++; $display("FAIL basic_byte_data_stable got=%0d exp=0", unstable); end
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL basic_busy_after got=%b exp=0", busy); end
    vectors++; if (overrun !== 1'b0) begin miscompares++; $display("FAIL basic_overrun got=%b exp=0", overrun); end
  endtask

  task automatic test_overrun();
    bit sl, dl, oc, to;
    logic [NBITS-1:0] w;
    w = 32'hDEAD_BEEF;
    clear_obs();
    send_word(w, 4, 1'b0, 1, 0, sl, dl, oc, to);
    vectors++; if (to) begin miscompares++; $display("FAIL ovr_timeout got=1 exp=0"); end
    vectors++; if (obs_q.size() != NBYTES) begin miscompares++; $display("FAIL ovr_byte_count got=%0d exp=%0d", obs_q.size(), NBYTES); end
    for (int i = 0; i < NBYTES && i < obs_q.size(); i++) begin
      vectors++;
      if (obs_q[i] !== exp_byte(w, i)) begin
        miscompares++; $display("FAIL ovr_byte%0d got=%h exp=%h", i, obs_q[i], exp_byte(w, i));
      end
    end
    vectors++; if (wd_cnt != 1) begin miscompares++; $display("FAIL ovr_word_done_count got=%0d exp=1", wd_cnt); end
    vectors++; if (overrun !== 1'b1) begin miscompares++; $display("FAIL ovr_sticky got=%b exp=1", overrun); end
    repeat (3) tick();
    vectors++; if (overrun !== 1'b1) begin miscompares++; $display("FAIL ovr_sticky_idle got=%b exp=1", overrun); end
    clear_obs();
    send_word(32'h0BAD_F00D, 2, 1'b0, -1, 0, sl, dl, oc, to);
    vectors++; if (!oc) begin miscompares++; $display("FAIL ovr_cleared_on_accept got=1 exp=0"); end
    vectors++; if (overrun !== 1'b0) begin miscompares++; $display("FAIL ovr_after_next got=%b exp=0", overrun); end
  endtask

  task automatic test_spurious();
    bit sl, dl, oc, to;
    logic [NBITS-1:0] w;
    int starts_seen;
    w = 32'h0000_0001;
    clear_obs();
    starts_seen = 0;
    for (int c = 0; c < 4; c++) begin
      byte_done = 1'b1;
      tick();
      byte_done = 1'b0;
      if (byte_start === 1'b1 || busy === 1'b1) starts_seen++;
    end
    vectors++; if (starts_seen != 0) begin miscompares++; $display("FAIL spur_idle_activity got=%0d exp=0", starts_seen); end
    vectors++; if (obs_q.size() != 0) begin miscompares++; $display("FAIL spur_idle_bytes got=%0d exp=0", obs_q.size()); end
    send_word(w, 3, 1'b1, -1, 0, sl, dl, oc, to);
    vectors++; if (to) begin miscompares++; $display("FAIL spur_timeout got=1 exp=0"); end
    vectors++; if (obs_q.size() != NBYTES) begin miscompares++; $display("FAIL spur_byte_count got=%0d exp=%0d", obs_q.size(), NBYTES); end
    for (int i = 0; i < NBYTES && i < obs_q.size(); i++) begin
      vectors++;
      if (obs_q[i] !== exp_byte(w, i)) begin
        miscompares++; $display("FAIL spur_byte%0d got=%h exp=%h", i, obs_q[i], exp_byte(w, i));
      end
    end
    vectors++; if (wd_cnt != 1) begin miscompares++; $display("FAIL spur_word_done_count got=%0d exp=1", wd_cnt); end
    repeat (3) tick();
    vectors++; if (obs_q.size() != NBYTES) begin miscompares++; $display("FAIL spur_extra_bytes got=%0d exp=%0d", obs_q.size(), NBYTES); end
  endtask

  task automatic test_reset_midword();
    bit sl, dl, oc, to;
    logic [NBITS-1:0] w;
    clear_obs();
    send_word(32'hCAFE_F00D, 2, 1'b0, -1, 2, sl, dl, oc, to);
    #2;
    rst = 1'b0;
    #1;
    vectors++; if (byte_start !== 1'b0 || word_done !== 1'b0 || busy !== 1'b0 || overrun !== 1'b0 || byte_data !== '0) begin
      miscompares++;
      $display("FAIL midreset_outputs got=bs%b wd%b bz%b ov%b bd%h exp=all_zero", byte_start, word_done, busy, overrun, byte_data);
    end
    repeat (2) tick();
    rst = 1'b1;
    repeat (3) tick();
    vectors++; if (wd_cnt != 0) begin miscompares++; $display("FAIL midreset_word_done got=%0d exp=0", wd_cnt); end
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL midreset_idle got=%b exp=0", busy); end
    w = 32'h1234_5678;
    clear_obs();
    send_word(w, 2, 1'b0, -1, 0, sl, dl, oc, to);
    vectors++; if (obs_q.size() != NBYTES) begin miscompares++; $display("FAIL midreset_byte_count got=%0d exp=%0d", obs_q.size(), NBYTES); end
    for (int i = 0; i < NBYTES && i < obs_q.size(); i++) begin
      vectors++;
      if (obs_q[i] !== exp_byte(w, i)) begin
        miscompares++; $display("FAIL midreset_byte%0d got=%h exp=%h", i, obs_q[i], exp_byte(w, i));
      end
    end
  endtask

  task automatic test_back_to_back();
    bit sl, dl, oc, to;
    logic [NBITS-1:0] w;
    for (int k = 0; k < 16; k++) begin
      w = NBITS'($urandom);
      clear_obs();
      send_word(w, int'($urandom_range(1, 6)), 1'($urandom_range(0, 1)), -1, 0, sl, dl, oc, to);
      vectors++; if (to || !sl || !dl) begin miscompares++; $display("FAIL b2b%0d_handshake got=to%b sl%b dl%b exp=to0 sl1 dl1", k, to, sl, dl); end
      vectors++; if (obs_q.size() != NBYTES || wd_cnt != 1 || unstable != 0) begin
        miscompares++; $display("FAIL b2b%0d_counts got=bytes%0d wd%0d unst%0d exp=bytes%0d wd1 unst0", k, obs_q.size(), wd_cnt, unstable, NBYTES);
      end
      for (int i = 0; i < NBYTES && i < obs_q.size(); i++) begin
        vectors++;
        if (obs_q[i] !== exp_byte(w, i)) begin
          miscompares++; $display("FAIL b2b%0d_byte%0d got=%h exp=%h", k, i, obs_q[i], exp_byte(w, i));
        end
      end
    end
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    word_start  = 1'b0;
    word_data   = '0;
    byte_done   = 1'b0;
    held        = '0;
    clear_obs();
    test_reset();
    test_basic();
    test_overrun();
    test_spurious();
    test_reset_midword();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire
